// File: rtl/video_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// video_mem_pkg
// Shared types and constants for the video memory arbiter slice.
//   arb_state_t  : arbiter slot state (IDLE, VID, CPU_RD, CPU_WR)
//   VID_ADDR_W   : default address width of every address bus
//   DATA_W       : RAM data width
//   is_cpu_state : true for either CPU slot state
// -----------------------------------------------------------------------------
package video_mem_pkg;

    localparam int VID_ADDR_W = 17;
    localparam int DATA_W     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VID    = 2'd1,
        CPU_RD = 2'd2,
        CPU_WR = 2'd3
    } arb_state_t;

    function automatic logic is_cpu_state(input arb_state_t s);
        return (s == CPU_RD) || (s == CPU_WR);
    endfunction

endpackage

// File: rtl/video_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// video_mem_arbiter_if
// Bundles the video fetch port, the CPU req/ack port and the single-port RAM
// port of the video memory arbiter.
//   slave  modport : arbiter side (drives vid_data, cpu_*data/ack, ram_*, video_slot)
//   master modport : requester/RAM side (drives requests, addresses, ram_rdata)
// Parameter ADDR_W : width of vid_addr, cpu_addr and ram_addr.
// -----------------------------------------------------------------------------
interface video_mem_arbiter_if
    import video_mem_pkg::*;
#(
    parameter int ADDR_W = VID_ADDR_W
);
    // video fetch port
    logic              video_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    // CPU port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    // RAM port
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    // debug
    logic              video_slot;

    modport slave (
        input  video_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vid_data, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata, video_slot
    );

    modport master (
        output video_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vid_data, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata, video_slot
    );

endinterface

// File: rtl/video_mem_arbiter_slot_timer.sv
// -----------------------------------------------------------------------------
// video_mem_slot_timer
// Times one RAM access slot of RAM_LAT+1 cycles.
//   clk_sys   in  : system clock
//   reset     in  : synchronous active-high reset, aborts a running slot
//   start_i   in  : a slot is entered on this edge (restarts the count)
//   capture_o out : last cycle of the slot; RAM read data is valid now
//   done_o    out : no slot running, or the running slot ends this cycle,
//                   so a new slot may be started on the coming edge
// Parameter RAM_LAT : RAM read latency in cycles (1 or 2).
// -----------------------------------------------------------------------------
module video_mem_slot_timer #(
    parameter int RAM_LAT = 1
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic start_i,
    output logic capture_o,
    output logic done_o
);

    localparam int                CNT_W    = $clog2(RAM_LAT + 2);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(RAM_LAT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    // next-state of the slot counter; a start in the final cycle chains slots
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = {CNT_W{1'b0}};
        end else if (active_q) begin
            if (cnt_q == LAST_CNT) begin
                active_d = 1'b0;
                cnt_d    = {CNT_W{1'b0}};
            end else begin
                cnt_d    = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d    = {CNT_W{1'b0}};
            active_d = 1'b0;
        end
    end

    // slot counter registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q    <= {CNT_W{1'b0}};
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign capture_o = active_q && (cnt_q == LAST_CNT);
    assign done_o    = !active_q || capture_o;

endmodule

// File: rtl/video_mem_arbiter.sv
// -----------------------------------------------------------------------------
// video_mem_arbiter
// Shares one single-port synchronous RAM between the video controller fetch
// port and a CPU req/ack port. Video has priority, but when both request the
// arbiter alternates so the CPU always makes progress.
//   clk_sys  in : system clock (only clock)
//   reset    in : synchronous active-high reset; aborts any slot in flight
//   bus         : video_mem_arbiter_if.slave (video, CPU and RAM ports)
// Parameters: ADDR_W (address width), RAM_LAT (RAM read latency, 1 or 2).
// Build option: define VIDEO_FETCH_CACHE_EN to add a one-entry video address
// tag that skips a RAM read when the same video address is fetched again.
// -----------------------------------------------------------------------------
module video_mem_arbiter
    import video_mem_pkg::*;
#(
    parameter int ADDR_W  = VID_ADDR_W,
    parameter int RAM_LAT = 1
) (
    input  logic                clk_sys,
    input  logic                reset,
    video_mem_arbiter_if.slave  bus
);

    arb_state_t        state_q, state_d;
    logic              last_vid_q, last_vid_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              video_slot_q;

    logic              tmr_capture_s;
    logic              tmr_done_s;
    logic              slot_start_s;
    logic              cache_hit_s;
    logic              cpu_done_s;
    logic              cpu_req_s;
    logic              vid_req_s;
    logic              take_vid_s;
    logic              take_cpu_s;

    video_mem_slot_timer #(
        .RAM_LAT   (RAM_LAT)
    ) u_slot_timer (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .start_i   (slot_start_s),
        .capture_o (tmr_capture_s),
        .done_o    (tmr_done_s)
    );

    // The request that a CPU slot is just finishing (or whose ack is visible
    // now) is still held by the requester; it must not start a second slot.
    assign cpu_done_s = tmr_capture_s && is_cpu_state(state_q);
    assign cpu_req_s  = bus.cpu_req && !cpu_ack_q && !cpu_done_s;
    assign vid_req_s  = bus.video_req && !cache_hit_s;

    // Video wins unless it also had the previous slot and the CPU is waiting.
    assign take_vid_s = vid_req_s && (!cpu_req_s || !last_vid_q);
    assign take_cpu_s = cpu_req_s && !take_vid_s;

`ifdef VIDEO_FETCH_CACHE_EN
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              tag_vld_q, tag_vld_d;

    assign cache_hit_s = tag_vld_q && (bus.vid_addr == tag_q);

    // tag update: fill on each video slot, drop on a CPU write to the tag
    always_comb begin
        tag_d     = tag_q;
        tag_vld_d = tag_vld_q;
        if (tmr_done_s && take_vid_s) begin
            tag_d     = bus.vid_addr;
            tag_vld_d = 1'b1;
        end else if (tmr_done_s && take_cpu_s && bus.cpu_we && (bus.cpu_addr == tag_q)) begin
            tag_vld_d = 1'b0;
        end else begin
            tag_vld_d = tag_vld_q;
        end
    end

    // tag registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tag_q     <= {ADDR_W{1'b0}};
            tag_vld_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            tag_vld_q <= tag_vld_d;
        end
    end
`else
    assign cache_hit_s = 1'b0;
`endif

    // FSM next state, slot entry and data capture. The final cycle of a slot
    // doubles as the IDLE decision cycle so slots can run back to back; that
    // keeps worst-case video latency at two slots.
    always_comb begin
        state_d      = state_q;
        last_vid_d   = last_vid_q;
        ram_addr_d   = ram_addr_q;
        ram_we_d     = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        vid_data_d   = vid_data_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_ack_d    = 1'b0;
        slot_start_s = 1'b0;

        if (tmr_capture_s) begin
            case (state_q)
                VID: begin
                    vid_data_d = bus.ram_rdata;
                end
                CPU_RD: begin
                    cpu_rdata_d = bus.ram_rdata;
                    cpu_ack_d   = 1'b1;
                end
                CPU_WR: begin
                    cpu_ack_d = 1'b1;
                end
                default: begin
                    cpu_ack_d = 1'b0;
                end
            endcase
        end else begin
            cpu_ack_d = 1'b0;
        end

        if (tmr_done_s) begin
            if (take_vid_s) begin
                state_d      = VID;
                ram_addr_d   = bus.vid_addr;
                last_vid_d   = 1'b1;
                slot_start_s = 1'b1;
            end else if (take_cpu_s) begin
                state_d      = bus.cpu_we ? CPU_WR : CPU_RD;
                ram_addr_d   = bus.cpu_addr;
                ram_we_d     = bus.cpu_we;
                ram_wdata_d  = bus.cpu_we ? bus.cpu_wdata : ram_wdata_q;
                last_vid_d   = 1'b0;
                slot_start_s = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            state_d = state_q;
        end
    end

    // state and output registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            last_vid_q   <= 1'b0;
            ram_addr_q   <= {ADDR_W{1'b0}};
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= {DATA_W{1'b0}};
            vid_data_q   <= {DATA_W{1'b0}};
            cpu_rdata_q  <= {DATA_W{1'b0}};
            cpu_ack_q    <= 1'b0;
            video_slot_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_vid_q   <= last_vid_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            vid_data_q   <= vid_data_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            video_slot_q <= (state_d == VID);
        end
    end

    assign bus.vid_data   = vid_data_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.video_slot = video_slot_q;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_video_mem_arbiter
// Directed bench for video_mem_arbiter. u_dut1 runs with RAM_LAT=1, u_dut2
// with RAM_LAT=2; each has its own behavioural synchronous RAM. Expected
// values are hand-computed from the slot timing.
// -----------------------------------------------------------------------------
module tb_video_mem_arbiter;

    logic clk_sys;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic        pre_we;
    logic [16:0] pre_addr;
    logic [7:0]  pre_data;

    video_mem_arbiter_if #(.ADDR_W(17)) vif1 ();
    video_mem_arbiter_if #(.ADDR_W(17)) vif2 ();

    video_mem_arbiter #(.ADDR_W(17), .RAM_LAT(1)) u_dut1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (vif1)
    );

    video_mem_arbiter #(.ADDR_W(17), .RAM_LAT(2)) u_dut2 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (vif2)
    );

    // behavioural RAMs (1-cycle and 2-cycle read latency), preload port
    logic [7:0] mem1 [0:131071];
    logic [7:0] mem2 [0:131071];
    logic [7:0] rd1_q;
    logic [7:0] rd2a_q;
    logic [7:0] rd2b_q;

    always @(posedge clk_sys) begin
        if (vif1.ram_we) mem1[vif1.ram_addr] <= vif1.ram_wdata;
        else if (pre_we) mem1[pre_addr] <= pre_data;
        rd1_q <= mem1[vif1.ram_addr];
    end

    always @(posedge clk_sys) begin
        if (vif2.ram_we) mem2[vif2.ram_addr] <= vif2.ram_wdata;
        else if (pre_we) mem2[pre_addr] <= pre_data;
        rd2a_q <= mem2[vif2.ram_addr];
        rd2b_q <= rd2a_q;
    end

    assign vif1.ram_rdata = rd1_q;
    assign vif2.ram_rdata = rd2b_q;

    initial clk_sys = 1'b0;
    always #8 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        pre_we = 1'b0; pre_addr = 17'h0; pre_data = 8'h0;
        vif1.video_req = 1'b0; vif1.vid_addr = 17'h0;
        vif1.cpu_req = 1'b0; vif1.cpu_we = 1'b0; vif1.cpu_addr = 17'h0; vif1.cpu_wdata = 8'h0;
        vif2.video_req = 1'b0; vif2.vid_addr = 17'h0;
        vif2.cpu_req = 1'b0; vif2.cpu_we = 1'b0; vif2.cpu_addr = 17'h0; vif2.cpu_wdata = 8'h0;

        // preload both RAMs while reset is held
        pre_we = 1'b1;
        pre_addr = 17'h01234; pre_data = 8'hA5; tick();
        pre_addr = 17'h00010; pre_data = 8'h3C; tick();
        pre_addr = 17'h00200; pre_data = 8'h99; tick();
        pre_addr = 17'h00100; pre_data = 8'h5C; tick();
        pre_we = 1'b0;

        // reset values
        check_eq("rst_vid_data",  32'(vif1.vid_data),   32'h0);
        check_eq("rst_cpu_rdata", 32'(vif1.cpu_rdata),  32'h0);
        check_eq("rst_ack",       32'(vif1.cpu_ack),    32'h0);
        check_eq("rst_ram_we",    32'(vif1.ram_we),     32'h0);
        check_eq("rst_ram_addr",  32'(vif1.ram_addr),   32'h0);
        check_eq("rst_ram_wdata", 32'(vif1.ram_wdata),  32'h0);
        check_eq("rst_slot",      32'(vif1.video_slot), 32'h0);
        reset = 1'b0;

        // video only, uncontended
        vif1.video_req = 1'b1; vif1.vid_addr = 17'h01234;
        tick();
        check_eq("v_ram_addr", 32'(vif1.ram_addr),   32'h01234);
        check_eq("v_slot",     32'(vif1.video_slot), 32'h1);
        vif1.video_req = 1'b0;
        tick();
        check_eq("v_data_early", 32'(vif1.vid_data), 32'h0);
        tick();
        check_eq("v_data",     32'(vif1.vid_data),   32'hA5);
        check_eq("v_slot_end", 32'(vif1.video_slot), 32'h0);

        // CPU write 0x5A to the top address
        vif1.cpu_req = 1'b1; vif1.cpu_we = 1'b1; vif1.cpu_addr = 17'h1FFFF; vif1.cpu_wdata = 8'h5A;
        tick();
        check_eq("w_ram_we",    32'(vif1.ram_we),    32'h1);
        check_eq("w_ram_addr",  32'(vif1.ram_addr),  32'h1FFFF);
        check_eq("w_ram_wdata", 32'(vif1.ram_wdata), 32'h5A);
        check_eq("w_ack0",      32'(vif1.cpu_ack),   32'h0);
        tick();
        check_eq("w_we_single", 32'(vif1.ram_we),    32'h0);
        check_eq("w_ack1",      32'(vif1.cpu_ack),   32'h0);
        tick();
        check_eq("w_ack",       32'(vif1.cpu_ack),   32'h1);
        vif1.cpu_req = 1'b0; vif1.cpu_we = 1'b0;
        tick();
        check_eq("w_ack_pulse", 32'(vif1.cpu_ack),   32'h0);
        check_eq("w_no_rewr",   32'(vif1.ram_we),    32'h0);

        // CPU read back
        vif1.cpu_req = 1'b1; vif1.cpu_we = 1'b0; vif1.cpu_addr = 17'h1FFFF;
        tick();
        check_eq("r_ram_addr", 32'(vif1.ram_addr), 32'h1FFFF);
        check_eq("r_ram_we",   32'(vif1.ram_we),   32'h0);
        tick();
        tick();
        check_eq("r_ack",   32'(vif1.cpu_ack),   32'h1);
        check_eq("r_rdata", 32'(vif1.cpu_rdata), 32'h5A);
        vif1.cpu_req = 1'b0;
        tick();
        check_eq("r_ack_pulse", 32'(vif1.cpu_ack),   32'h0);
        check_eq("r_rdata_hold", 32'(vif1.cpu_rdata), 32'h5A);

        // contention: last slot was CPU, so video goes first, then CPU, then video
        vif1.video_req = 1'b1; vif1.vid_addr = 17'h00100;
        vif1.cpu_req = 1'b1; vif1.cpu_we = 1'b0; vif1.cpu_addr = 17'h00010;
        tick();
        check_eq("c_vid1_slot", 32'(vif1.video_slot), 32'h1);
        check_eq("c_vid1_addr", 32'(vif1.ram_addr),   32'h00100);
        tick();
        tick();
        check_eq("c_vid1_data", 32'(vif1.vid_data),   32'h5C);
        check_eq("c_cpu_slot",  32'(vif1.video_slot), 32'h0);
        check_eq("c_cpu_addr",  32'(vif1.ram_addr),   32'h00010);
        vif1.vid_addr = 17'h00200;
        tick();
        check_eq("c_ack_early", 32'(vif1.cpu_ack), 32'h0);
        tick();
        check_eq("c_ack",       32'(vif1.cpu_ack),    32'h1);
        check_eq("c_rdata",     32'(vif1.cpu_rdata),  32'h3C);
        check_eq("c_vid2_slot", 32'(vif1.video_slot), 32'h1);
        check_eq("c_vid2_addr", 32'(vif1.ram_addr),   32'h00200);
        vif1.cpu_req = 1'b0;
        tick();
        check_eq("c_ack_pulse", 32'(vif1.cpu_ack), 32'h0);
        tick();
        check_eq("c_vid2_data", 32'(vif1.vid_data), 32'h99);
        vif1.video_req = 1'b0;
        tick();
        tick();

        // reset in the middle of a video slot, CPU request pending
        vif1.video_req = 1'b1; vif1.vid_addr = 17'h01234;
        tick();
        check_eq("rs_slot_on", 32'(vif1.video_slot), 32'h1);
        reset = 1'b1;
        vif1.cpu_req = 1'b1; vif1.cpu_we = 1'b0; vif1.cpu_addr = 17'h00010;
        tick();
        check_eq("rs_vid_data",  32'(vif1.vid_data),   32'h0);
        check_eq("rs_cpu_rdata", 32'(vif1.cpu_rdata),  32'h0);
        check_eq("rs_slot",      32'(vif1.video_slot), 32'h0);
        check_eq("rs_ram_addr",  32'(vif1.ram_addr),   32'h0);
        check_eq("rs_ram_wdata", 32'(vif1.ram_wdata),  32'h0);
        check_eq("rs_ack_a",     32'(vif1.cpu_ack),    32'h0);
        tick();
        check_eq("rs_ack_b", 32'(vif1.cpu_ack), 32'h0);
        tick();
        check_eq("rs_ack_c", 32'(vif1.cpu_ack), 32'h0);
        reset = 1'b0;
        vif1.cpu_req = 1'b0; vif1.video_req = 1'b0;
        tick();
        check_eq("rs_after_data", 32'(vif1.vid_data), 32'h0);
        check_eq("rs_after_ack",  32'(vif1.cpu_ack),  32'h0);

        // same video address twice, then CPU write to it and a refetch
        vif1.video_req = 1'b1; vif1.vid_addr = 17'h00200;
        tick();
        check_eq("k_first_slot", 32'(vif1.video_slot), 32'h1);
        vif1.video_req = 1'b0;
        tick();
        tick();
        check_eq("k_first_data", 32'(vif1.vid_data), 32'h99);
        vif1.video_req = 1'b1;
        tick();
`ifdef VIDEO_FETCH_CACHE_EN
        check_eq("k_repeat_slot", 32'(vif1.video_slot), 32'h0);
`else
        check_eq("k_repeat_slot", 32'(vif1.video_slot), 32'h1);
`endif
        vif1.video_req = 1'b0;
        tick();
        tick();
        check_eq("k_repeat_data", 32'(vif1.vid_data), 32'h99);
        vif1.cpu_req = 1'b1; vif1.cpu_we = 1'b1; vif1.cpu_addr = 17'h00200; vif1.cpu_wdata = 8'h77;
        tick();
        check_eq("k_wr_we", 32'(vif1.ram_we), 32'h1);
        tick();
        tick();
        check_eq("k_wr_ack", 32'(vif1.cpu_ack), 32'h1);
        vif1.cpu_req = 1'b0; vif1.cpu_we = 1'b0;
        tick();
        vif1.video_req = 1'b1; vif1.vid_addr = 17'h00200;
        tick();
        check_eq("k_refetch_slot", 32'(vif1.video_slot), 32'h1);
        vif1.video_req = 1'b0;
        tick();
        tick();
        check_eq("k_refetch_data", 32'(vif1.vid_data), 32'h77);

        // RAM_LAT=2 instance: 3-cycle slot, data 3 cycles after sampling
        vif2.video_req = 1'b1; vif2.vid_addr = 17'h01234;
        tick();
        check_eq("l2_ram_addr", 32'(vif2.ram_addr),   32'h01234);
        check_eq("l2_slot0",    32'(vif2.video_slot), 32'h1);
        vif2.video_req = 1'b0;
        tick();
        tick();
        check_eq("l2_slot2",      32'(vif2.video_slot), 32'h1);
        check_eq("l2_data_early", 32'(vif2.vid_data),   32'h0);
        tick();
        check_eq("l2_data",     32'(vif2.vid_data),   32'hA5);
        check_eq("l2_slot_end", 32'(vif2.video_slot), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_mem_arbiter.md
Name: video_mem_arbiter

Overview:
Memory-side responder for the video controller's fetch port. It serves vid_addr/video_req reads for pixel and roller-RAM bytes and returns data on vid_data, which feeds the controller's din. The CPU shares the same single-port synchronous RAM through a req/ack handshake. Video has priority, and forced alternation guarantees CPU progress.

Parameters:
ADDR_W, 17, width of every address bus
RAM_LAT, 1, synchronous RAM read latency in clk_sys cycles (1 or 2)

Ports:
clk_sys  in  1  64 MHz system clock, the only clock
reset  in  1  synchronous, active-high reset
video_req  in  1  video fetch request, level, sampled every clk_sys
vid_addr  in  ADDR_W  video fetch address
vid_data  out  8  last video read data, held until the next video read completes
cpu_req  in  1  CPU request, level; held with cpu_we/cpu_addr/cpu_wdata stable until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  CPU read data, valid when cpu_ack=1, held until the next CPU read
cpu_ack  out  1  one-cycle completion pulse
ram_addr  out  ADDR_W  RAM address, registered
ram_we  out  1  RAM write strobe, registered, one cycle
ram_wdata  out  8  RAM write data, registered
ram_rdata  in  8  RAM read data, valid RAM_LAT cycles after ram_addr
video_slot  out  1  high while a video access is in flight (debug)

Behaviour:
- Reset values:
  - vid_data=0, cpu_rdata=0, cpu_ack=0, ram_we=0, ram_addr=0, ram_wdata=0, video_slot=0.
  - State=IDLE, last_was_video=0.
- States: IDLE, VID, CPU_RD, CPU_WR.
- Each slot lasts RAM_LAT+1 cycles and is timed by a slot counter of width clog2(RAM_LAT+2).
- Arbitration in IDLE, evaluated every cycle:
  - video_req alone -> VID.
  - cpu_req alone -> CPU_RD or CPU_WR, selected by cpu_we.
  - Both requests and last_was_video=0 -> VID.
  - Both requests and last_was_video=1 -> CPU.
  - Neither -> stay in IDLE.
- Entry to any slot latches the chosen address into ram_addr on the same edge.
- last_was_video is set on VID entry and cleared on CPU entry.
- VID:
  - video_slot=1.
  - After RAM_LAT cycles, ram_rdata is captured into vid_data.
  - The next cycle returns to IDLE.
  - vid_addr is sampled only at slot entry; later changes affect the next slot only.
- CPU_RD:
  - Same timing as VID.
  - ram_rdata is captured into cpu_rdata, and cpu_ack pulses in the capture cycle.
- CPU_WR:
  - ram_we=1 for exactly the first cycle, with ram_wdata=cpu_wdata.
  - cpu_ack pulses in the last cycle of the slot.
  - The slot length matches the read slot.
- cpu_ack never lasts more than one cycle. After cpu_ack, the requester must drop cpu_req or present a new request. A request still asserted in the cycle after cpu_ack counts as new.
- Latency, RAM_LAT=1:
  - Video, uncontended: data 2 cycles after video_req is sampled.
  - Worst case, CPU slot in progress: 4 cycles, which is one 16 MHz pixel period. The controller's din is therefore valid at the next ce_pix.
- Continuous video_req with cpu_req pending: slots alternate VID, CPU, VID, and so on.
- Reset during a slot aborts it on that edge:
  - ram_we goes low and no cpu_ack is issued.
  - A write whose ram_we was already emitted is not rolled back.
- Address arithmetic is plain pass-through; no width truncation.

Optional Feature:
VIDEO_FETCH_CACHE_EN
- Defined:
  - A one-entry tag holds the last video address plus a valid bit.
  - When video_req is high and vid_addr matches the tag, vid_data is kept, no VID slot is used, and the CPU may take the slot in the same IDLE cycle.
  - A CPU write whose address equals the tag clears valid.
  - Reset clears valid.
- Undefined: every video_req produces a RAM read, and the tag logic is absent.

Decomposition:
- Package video_mem_pkg:
  - state enum arb_state_t {IDLE, VID, CPU_RD, CPU_WR}.
  - Localparams VID_ADDR_W=17 and DATA_W=8.
- Sub-module video_mem_slot_timer: a slot counter with start, done and capture outputs, parameterised by RAM_LAT.

Test Plan:
1. Reset: hold reset 3 cycles mid-VID -> all outputs 0 on the next edge; state IDLE; no cpu_ack.
2. Video only: RAM[0x01234]=0xA5, video_req=1, vid_addr=0x01234 -> ram_addr=0x01234 after 1 cycle; vid_data=0xA5 2 cycles after sampling (RAM_LAT=1).
3. CPU write then read: write 0x5A to 0x1FFFF -> ram_we is a single cycle; cpu_ack at cycle 2. Then read 0x1FFFF -> cpu_rdata=0x5A with cpu_ack.
4. Contention: video_req=1 continuously and cpu_req read at 0x00010 -> slot order VID, CPU, VID; cpu_ack within 4 cycles; every vid_data update within 4 cycles of a vid_addr change.
5. RAM_LAT=2 build: repeat scenario 2 -> vid_data valid 3 cycles after sampling; slot length 3.
6. VIDEO_FETCH_CACHE_EN: repeat vid_addr=0x00200 twice -> only one VID slot. A CPU write to 0x00200 with 0x77 followed by video_req -> a new VID slot and vid_data=0x77.
